// File: rtl/iob_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// iob_pkg
// Shared definitions for the iob program/data SRAM arbiter.
//   resp_src_e          : which requester owns the response slot
//   DEFAULT_MEM_BYTES   : default SRAM size in bytes (power of two)
//   DEFAULT_STARVE_MAX  : default cap on data grants while a fetch waits
//   in_range()          : true when a byte address lies inside [0, size)
// ---------------------------------------------------------------------------
package iob_pkg;

   typedef enum logic [1:0] {
      RESP_NONE   = 2'd0,
      RESP_IFETCH = 2'd1,
      RESP_DATA   = 2'd2
   } resp_src_e;

   localparam int unsigned DEFAULT_MEM_BYTES  = 65536;
   localparam int unsigned DEFAULT_STARVE_MAX = 4;

   // size is 33 bits wide so a full 4 GiB window is still expressible
   function automatic logic in_range(input logic [31:0] addr, input logic [32:0] size);
      return ({1'b0, addr} < size);
   endfunction

endpackage

// File: rtl/iob_mem_arb_prio.sv
// ---------------------------------------------------------------------------
// iob_arb_prio
// Two-input fixed-priority arbiter (data over fetch) with a starvation
// counter that forces a waiting fetch through after STARVE_MAX data grants.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : fetch request pending
//   d_req      : data request pending
//   i_gnt      : fetch granted (combinational)
//   d_gnt      : data granted (combinational)
// ---------------------------------------------------------------------------
module iob_arb_prio #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

   localparam int unsigned CNT_W = ($clog2(STARVE_MAX + 1) > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [CNT_W-1:0] starve_q;
   logic             starve_hit;

   assign starve_hit = (starve_q == CNT_W'(STARVE_MAX));

   // Grants are held off while reset is asserted so no output leaks out of reset
   assign i_gnt = rst_n & i_req & (~d_req | starve_hit);
   assign d_gnt = rst_n & d_req & ~i_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (!i_req || i_gnt) begin
         starve_q <= '0;
      end else if (d_gnt && !starve_hit) begin
         starve_q <= starve_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/iob_mem_arb.sv
// ---------------------------------------------------------------------------
// iob_mem_arb
// Shares one single-port synchronous SRAM between the core fetch port and
// the core data port. One access per cycle; the response comes back exactly
// one cycle after the grant, tagged with PC (fetch) or request tag (data).
// Out-of-range addresses and load+store requests answer with an error and
// never touch the SRAM.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   core__i_*                      : fetch request (ren, byte addr)
//   i__core_*                      : fetch accept and response (val, rdata, pc, error)
//   core__d_*                      : data request (addr, wdata, ren, wen, tag)
//   d__core_*                      : data accept and response (val, rdata, tag, error)
//   mem_en/mem_we/mem_addr/mem_wdata: SRAM drive (word address)
//   mem_rdata                      : SRAM read data, one cycle after mem_en
//
// Response state (resp_src_q, error carried in resp_err_q):
//   state       | meaning
//   RESP_NONE   | no response this cycle
//   RESP_IFETCH | fetch response (ERR_I when resp_err_q)
//   RESP_DATA   | load data / store ack (ERR_D when resp_err_q)
// ---------------------------------------------------------------------------
module iob_mem_arb
   import iob_pkg::*;
#(
   parameter int unsigned MEM_BYTES  = DEFAULT_MEM_BYTES,
   parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX,
   parameter int unsigned TAG_W      = 11
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            core__i_ren,
   input  logic [31:0]                     core__i_addr,
   output logic                            i__core_accept,
   output logic                            i__core_val,
   output logic [31:0]                     i__core_rdata,
   output logic [31:0]                     i__core_pc,
   output logic                            i__core_error,
   input  logic [31:0]                     core__d_addr,
   input  logic [31:0]                     core__d_wdata,
   input  logic                            core__d_ren,
   input  logic [3:0]                      core__d_wen,
   input  logic [TAG_W-1:0]                core__d_req_tag,
   output logic                            d__core_accept,
   output logic                            d__core_val,
   output logic [31:0]                     d__core_rdata,
   output logic [TAG_W-1:0]                d__core_resp_tag,
   output logic                            d__core_error,
   output logic                            mem_en,
   output logic [3:0]                      mem_we,
   output logic [$clog2(MEM_BYTES)-3:0]    mem_addr,
   output logic [31:0]                     mem_wdata,
   input  logic [31:0]                     mem_rdata
);

   localparam int unsigned AB = $clog2(MEM_BYTES);

   logic        d_req;
   logic        d_illegal;
   logic        i_gnt;
   logic        d_gnt;
   logic [31:0] sel_addr;
   logic        sel_ok;
   logic        acc_ok;

   resp_src_e        resp_src_q;
   logic             resp_err_q;
   logic             resp_load_q;
   logic [31:0]      pc_q;
   logic [TAG_W-1:0] tag_q;

   assign d_req     = core__d_ren | (|core__d_wen);
   assign d_illegal = core__d_ren & (|core__d_wen);

   iob_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (core__i_ren),
      .d_req (d_req),
      .i_gnt (i_gnt),
      .d_gnt (d_gnt)
   );

   assign i__core_accept = i_gnt;
   assign d__core_accept = d_gnt;

   assign sel_addr = d_gnt ? core__d_addr : core__i_addr;
   assign sel_ok   = in_range(sel_addr, 33'(MEM_BYTES));

   // A granted access reaches the SRAM only if it is in range and not illegal
   assign acc_ok = (i_gnt | (d_gnt & ~d_illegal)) & sel_ok;

   assign mem_en    = acc_ok;
   assign mem_we    = (acc_ok & d_gnt) ? core__d_wen : 4'b0000;
   assign mem_addr  = acc_ok ? sel_addr[AB-1:2] : '0;
   assign mem_wdata = (acc_ok & d_gnt) ? core__d_wdata : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_src_q  <= RESP_NONE;
         resp_err_q  <= 1'b0;
         resp_load_q <= 1'b0;
         pc_q        <= '0;
         tag_q       <= '0;
      end else begin
         if (i_gnt) begin
            resp_src_q <= RESP_IFETCH;
         end else if (d_gnt) begin
            resp_src_q <= RESP_DATA;
         end else begin
            resp_src_q <= RESP_NONE;
         end
         resp_err_q  <= (i_gnt | d_gnt) & ~acc_ok;
         // only a successful load returns SRAM data; store acks read as 0
         resp_load_q <= d_gnt & core__d_ren & acc_ok;
         pc_q        <= i_gnt ? core__i_addr : '0;
         tag_q       <= d_gnt ? core__d_req_tag : '0;
      end
   end

   assign i__core_val   = (resp_src_q == RESP_IFETCH);
   assign i__core_error = i__core_val & resp_err_q;
   assign i__core_rdata = (i__core_val & ~resp_err_q) ? mem_rdata : 32'h0;
   assign i__core_pc    = pc_q;

   assign d__core_val      = (resp_src_q == RESP_DATA);
   assign d__core_error    = d__core_val & resp_err_q;
   assign d__core_rdata    = (d__core_val & resp_load_q) ? mem_rdata : 32'h0;
   assign d__core_resp_tag = tag_q;

endmodule

// File: tb/tb_iob_mem_arb.sv
module tb_iob_mem_arb;

   localparam int unsigned MEM_BYTES  = 65536;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned TAG_W      = 11;
   localparam int unsigned WORDS      = MEM_BYTES / 4;

   logic              clk;
   logic              rst_n;
   logic              i_ren;
   logic [31:0]       i_addr;
   logic              i__core_accept, i__core_val, i__core_error;
   logic [31:0]       i__core_rdata, i__core_pc;
   logic [31:0]       d_addr, d_wdata;
   logic              d_ren;
   logic [3:0]        d_wen;
   logic [TAG_W-1:0]  d_tag;
   logic              d__core_accept, d__core_val, d__core_error;
   logic [31:0]       d__core_rdata;
   logic [TAG_W-1:0]  d__core_resp_tag;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [13:0]       mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   iob_mem_arb #(
      .MEM_BYTES  (MEM_BYTES),
      .STARVE_MAX (STARVE_MAX),
      .TAG_W      (TAG_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .core__i_ren      (i_ren),
      .core__i_addr     (i_addr),
      .i__core_accept   (i__core_accept),
      .i__core_val      (i__core_val),
      .i__core_rdata    (i__core_rdata),
      .i__core_pc       (i__core_pc),
      .i__core_error    (i__core_error),
      .core__d_addr     (d_addr),
      .core__d_wdata    (d_wdata),
      .core__d_ren      (d_ren),
      .core__d_wen      (d_wen),
      .core__d_req_tag  (d_tag),
      .d__core_accept   (d__core_accept),
      .d__core_val      (d__core_val),
      .d__core_rdata    (d__core_rdata),
      .d__core_resp_tag (d__core_resp_tag),
      .d__core_error    (d__core_error),
      .mem_en           (mem_en),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM fixture driven by the DUT
   logic [31:0] sram [0:WORDS-1];
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= sram[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   // reference model state
   logic [31:0] ref_mem [0:WORDS-1];
   int          starve;
   logic        last_gi, last_gd;
   logic        obs_iacc;

   int n_vec;
   int n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) return 32'h0001_0000 + ($urandom_range(0, 255) << 2);
      if (r == 1) return 32'hFFFF_FFFC;
      return 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
   endfunction

   // One arbitration cycle: check grant/SRAM drive, predict and check response.
   task automatic step();
      logic        ip, dp, gi, gd, ill, oor, en;
      logic [31:0] a;
      logic [13:0] w;
      logic        nx_iv, nx_ie, nx_dv, nx_de;
      logic [31:0] nx_ir, nx_pc, nx_dr;
      logic [TAG_W-1:0] nx_tag;
      #1;
      ip = i_ren;
      dp = d_ren || (d_wen != 4'h0);
      gi = ip && (!dp || starve == STARVE_MAX);
      gd = dp && !gi;
      obs_iacc = i__core_accept;
      chk("i_accept", 64'(i__core_accept), 64'(gi));
      chk("d_accept", 64'(d__core_accept), 64'(gd));
      a   = gi ? i_addr : d_addr;
      w   = a[15:2];
      ill = gd && d_ren && (d_wen != 4'h0);
      oor = 64'(a) >= 64'(MEM_BYTES);
      en  = (gi || gd) && !oor && !ill;
      chk("mem_en", 64'(mem_en), 64'(en));
      if (en) begin
         chk("mem_addr", 64'(mem_addr), 64'(w));
         chk("mem_we", 64'(mem_we), 64'(gd ? d_wen : 4'h0));
         if (gd && d_wen != 4'h0) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
      end
      nx_iv = 1'b0; nx_ie = 1'b0; nx_ir = '0; nx_pc = '0;
      nx_dv = 1'b0; nx_de = 1'b0; nx_dr = '0; nx_tag = '0;
      if (gi) begin
         nx_iv = 1'b1;
         nx_ie = oor;
         nx_ir = oor ? 32'h0 : ref_mem[w];
         nx_pc = i_addr;
      end
      if (gd) begin
         nx_dv  = 1'b1;
         nx_de  = oor || ill;
         nx_tag = d_tag;
         if (!nx_de && d_ren) nx_dr = ref_mem[w];
         if (!nx_de && d_wen != 4'h0)
            for (int b = 0; b < 4; b++)
               if (d_wen[b]) ref_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
      end
      if (ip && gd) starve = (starve >= STARVE_MAX) ? STARVE_MAX : starve + 1;
      else          starve = 0;
      last_gi = gi;
      last_gd = gd;
      @(negedge clk);
      chk("i_val", 64'(i__core_val), 64'(nx_iv));
      chk("i_err", 64'(i__core_error), 64'(nx_ie));
      chk("i_rdata", 64'(i__core_rdata), 64'(nx_ir));
      if (nx_iv) chk("i_pc", 64'(i__core_pc), 64'(nx_pc));
      chk("d_val", 64'(d__core_val), 64'(nx_dv));
      chk("d_err", 64'(d__core_error), 64'(nx_de));
      chk("d_rdata", 64'(d__core_rdata), 64'(nx_dr));
      if (nx_dv) chk("d_tag", 64'(d__core_resp_tag), 64'(nx_tag));
   endtask

   task automatic idle_inputs();
      i_ren = 1'b0; i_addr = '0;
      d_ren = 1'b0; d_wen = '0; d_addr = '0; d_wdata = '0; d_tag = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_outs"}, 64'({i__core_accept, i__core_val, i__core_error, i__core_rdata, i__core_pc}), 64'(0));
      chk({tag, "_douts"}, 64'({d__core_accept, d__core_val, d__core_error, d__core_rdata, d__core_resp_tag}), 64'(0));
      chk({tag, "_mem"}, 64'({mem_en, mem_we, mem_addr}), 64'(0));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cnt, max_wait;
      n_vec = 0;
      n_err = 0;
      starve = 0;
      mem_rdata = '0;
      for (int i = 0; i < WORDS; i++) begin
         sram[i]    = 32'(i) * 32'h9E37_79B9;
         ref_mem[i] = 32'(i) * 32'h9E37_79B9;
      end
      sram[4] = 32'hDEADBEEF;  ref_mem[4] = 32'hDEADBEEF;
      sram[8] = 32'hCAFEF00D;  ref_mem[8] = 32'hCAFEF00D;

      // reset: outputs quiet even with requests present
      idle_inputs();
      rst_n = 1'b0;
      i_ren = 1'b1; i_addr = 32'h10;
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      // fetch alone
      i_ren = 1'b1; i_addr = 32'h10;
      step();
      chk("fetch_rdata", 64'(i__core_rdata), 64'(32'hDEADBEEF));
      chk("fetch_pc", 64'(i__core_pc), 64'(32'h10));
      idle_inputs();

      // store then load, back to back
      d_wen = 4'b0011; d_wdata = 32'h12345678; d_addr = 32'h20; d_tag = 11'd5;
      step();
      chk("store_ack_tag", 64'(d__core_resp_tag), 64'(5));
      idle_inputs();
      d_ren = 1'b1; d_addr = 32'h20; d_tag = 11'd6;
      step();
      chk("load_merge", 64'(d__core_rdata), 64'(32'hCAFE5678));
      idle_inputs();

      // out of range load
      d_ren = 1'b1; d_addr = 32'h0001_0000; d_tag = 11'd3;
      step();
      chk("oor_err", 64'({d__core_val, d__core_error, d__core_resp_tag}), 64'({1'b1, 1'b1, 11'd3}));
      idle_inputs();

      // illegal load+store, then readback unchanged
      d_ren = 1'b1; d_wen = 4'hF; d_addr = 32'h20; d_wdata = 32'hFFFFFFFF; d_tag = 11'd4;
      step();
      chk("illegal_err", 64'(d__core_error), 64'(1));
      idle_inputs();
      d_ren = 1'b1; d_addr = 32'h20; d_tag = 11'd7;
      step();
      chk("illegal_readback", 64'(d__core_rdata), 64'(32'hCAFE5678));
      idle_inputs();
      step();

      // contention: fetch and loads held for 10 cycles
      wait_cnt = 0;
      max_wait = 0;
      i_ren = 1'b1; i_addr = 32'h100;
      d_ren = 1'b1; d_addr = 32'h104;
      for (int k = 0; k < 10; k++) begin
         d_tag = 11'(k);
         step();
         chk("cont_pattern", 64'(obs_iacc), 64'((k % 5) == 4));
         if (obs_iacc) begin
            wait_cnt = 0;
            i_addr = i_addr + 32'h4;
         end else begin
            wait_cnt++;
            if (wait_cnt > max_wait) max_wait = wait_cnt;
         end
      end
      chk("cont_max_wait", 64'(max_wait), 64'(4));
      idle_inputs();
      step();

      // reset in the cycle after a load grant
      d_ren = 1'b1; d_addr = 32'h20; d_tag = 11'd9;
      #1;
      chk("rst_mid_acc", 64'(d__core_accept), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      starve = 0;
      step();
      step();

      // randomized traffic with hold-until-accept requesters
      for (int n = 0; n < 400; n++) begin
         if (!i_ren || last_gi) begin
            i_ren  = ($urandom_range(0, 3) != 0);
            i_addr = pick_addr();
         end
         if (!(d_ren || d_wen != 4'h0) || last_gd) begin
            int kind;
            kind    = $urandom_range(0, 15);
            d_addr  = pick_addr();
            d_wdata = $urandom;
            d_tag   = 11'($urandom);
            d_ren   = 1'b0;
            d_wen   = 4'h0;
            if (kind < 6) d_ren = 1'b1;
            else if (kind < 12) d_wen = 4'($urandom_range(1, 15));
            else if (kind == 12) begin
               d_ren = 1'b1;
               d_wen = 4'($urandom_range(1, 15));
            end
         end
         last_gi = 1'b0;
         last_gd = 1'b0;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
